// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS channel decoder: control tokens,
// alignment FSM state encoding and the bit-offset wrap helper.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    localparam logic [3:0] OFFSET_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } dec_state_e;

    // Word alignment walks offsets 0..9 and wraps back to 0.
    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off >= OFFSET_MAX) ? 4'd0 : 4'(off + 4'd1);
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol classifier: control-token match plus
// recovery of the 8-bit video byte from a 10-bit transition-minimised symbol.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_token,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [7:0] q;

    always_comb begin
        is_token = 1'b1;
        ctrl     = 2'b00;
        case (sym)
            TOK_C00: ctrl = 2'b00;
            TOK_C01: ctrl = 2'b01;
            TOK_C10: ctrl = 2'b10;
            TOK_C11: ctrl = 2'b11;
            default: is_token = 1'b0;
        endcase
    end

    // Bit 9 flags DC-balance inversion; bit 8 selects XOR vs XNOR chaining.
    always_comb begin
        q       = sym[9] ? ~sym[7:0] : sym[7:0];
        data    = '0;
        data[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: word alignment by control-token search, symbol decode
// and registered outputs. Optional lock-loss counter: TMDS_DEC_ERR_CNT_EN.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOCK_TOKENS   = 4
) (
    input  logic        pixclk,
    input  logic        rst,
    input  logic [9:0]  raw_in,
    output logic [7:0]  data_out,
    output logic [1:0]  c_out,
    output logic        de_out,
    output logic        locked,
    output logic [3:0]  slip_count,
    output logic [15:0] err_count
);

    localparam int TW = $clog2(SEARCH_WINDOW) + 1;
    localparam int CW = $clog2(LOCK_TOKENS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SEARCH_WINDOW - 1);
    localparam logic [CW-1:0] TOK_TARGET = CW'(LOCK_TOKENS);
    localparam logic [CW-1:0] TOK_ONE    = CW'(1);

    dec_state_e    state_q, state_d;
    logic [9:0]    in_q, in_d;
    logic [9:0]    sym_q, sym_d;
    logic [3:0]    offset_q, offset_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic [CW-1:0] tok_cnt_q, tok_cnt_d, tok_next;
    logic [7:0]    data_q, data_d;
    logic [1:0]    c_q, c_d;
    logic          de_q, de_d;
    logic          locked_q, locked_d;

    logic          tok;
    logic [1:0]    tok_c;
    logic [7:0]    vid_data;

    // Stage 1 keeps the previous word; stage 2 holds the symbol at the current offset.
    always_comb begin
        in_d  = raw_in;
        sym_d = 10'({raw_in, in_q} >> offset_q);
    end

    tmds_symbol_decode u_decode (
        .sym      (sym_q),
        .is_token (tok),
        .ctrl     (tok_c),
        .data     (vid_data)
    );

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        tok_cnt_d = tok_cnt_q;
        tok_next  = tok_cnt_q + TOK_ONE;
        timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
        timer_d   = timer_inc;

        case (state_q)
            ST_SEARCH: begin
                if (tok) begin
                    state_d   = (TOK_TARGET <= TOK_ONE) ? ST_LOCKED : ST_CHECK;
                    tok_cnt_d = TOK_ONE;
                    timer_d   = '0;
                end else if (timer_q >= TIMER_LAST) begin
                    offset_d = next_offset(offset_q);
                    timer_d  = '0;
                end
            end
            ST_CHECK: begin
                if (tok) begin
                    tok_cnt_d = tok_next;
                    timer_d   = '0;
                    if (tok_next >= TOK_TARGET) begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    // Offset and timer are kept so the search resumes where it was.
                    state_d   = ST_SEARCH;
                    tok_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                if (tok) begin
                    timer_d = '0;
                end else if (timer_q >= TIMER_LAST) begin
                    state_d   = ST_SEARCH;
                    offset_d  = next_offset(offset_q);
                    timer_d   = '0;
                    tok_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_SEARCH;
                tok_cnt_d = '0;
                timer_d   = '0;
            end
        endcase
    end

    // Outputs follow the next state so a lock is reported with its first symbol.
    always_comb begin
        data_d   = '0;
        de_d     = 1'b0;
        c_d      = 2'b00;
        locked_d = (state_d == ST_LOCKED);
        if (state_d == ST_LOCKED) begin
            if (tok) begin
                c_d = tok_c;
            end else begin
                c_d    = c_q;
                de_d   = 1'b1;
                data_d = vid_data;
            end
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            state_q   <= ST_SEARCH;
            in_q      <= '0;
            sym_q     <= '0;
            offset_q  <= '0;
            timer_q   <= '0;
            tok_cnt_q <= '0;
            data_q    <= '0;
            c_q       <= '0;
            de_q      <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_q      <= in_d;
            sym_q     <= sym_d;
            offset_q  <= offset_d;
            timer_q   <= timer_d;
            tok_cnt_q <= tok_cnt_d;
            data_q    <= data_d;
            c_q       <= c_d;
            de_q      <= de_d;
            locked_q  <= locked_d;
        end
    end

`ifdef TMDS_DEC_ERR_CNT_EN
    logic [15:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((state_q == ST_LOCKED) && (state_d == ST_SEARCH) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

    assign data_out   = data_q;
    assign c_out      = c_q;
    assign de_out     = de_q;
    assign locked     = locked_q;
    assign slip_count = offset_q;

endmodule
